led_scan_controller: RTL and testbench

LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

---
 rtl/led_scan_controller.sv | 60 ++++++
 tb/tb_led_scan_controller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/led_scan_controller.sv
// led_scan_controller: column-scan sequencer for an NxN LED grid with double-buffered frames
module led_scan_controller #(
    parameter int N        = 8,
    parameter int PRESCALE = 1024,
    parameter int BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [N*N-1:0]        cells_in,
    input  logic                  cells_valid,
    output logic                  cells_ready,
    output logic [$clog2(N):0]    x,
    output logic [N*N-1:0]        cells_out,
    output logic                  disp_ena,
    output logic                  frame_done
);
    localparam int PW = $clog2(PRESCALE);
    localparam int XW = $clog2(N) + 1;
    localparam logic [PW-1:0] PMAX    = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_P = PW'(BLANK);
    localparam logic [XW-1:0] XMAX    = XW'(N - 1);

    logic [PW-1:0]  pcnt, pcnt_nxt;
    logic [XW-1:0]  x_nxt;
    logic [N*N-1:0] pend_buf;
    logic           pending, col_end, wrap, capture, swap;

    always_comb begin
        col_end  = ena && (pcnt == PMAX);
        wrap     = col_end && (x == XMAX);
        pcnt_nxt = !ena ? pcnt : (pcnt == PMAX ? '0 : pcnt + PW'(1));
        x_nxt    = col_end ? (x == XMAX ? '0 : x + XW'(1)) : x;
        capture  = cells_valid && !pending;
        // swap only at frame boundaries, or immediately while the display is idle
        swap     = pending && (wrap || !ena);
    end

    assign cells_ready = !pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt       <= '0;
            x          <= '0;
            cells_out  <= '0;
            pend_buf   <= '0;
            pending    <= 1'b0;
            disp_ena   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pcnt       <= pcnt_nxt;
            x          <= x_nxt;
            frame_done <= wrap;
            disp_ena   <= ena && (pcnt_nxt >= BLANK_P);
            pending    <= capture ? 1'b1 : (swap ? 1'b0 : pending);
            if (capture) pend_buf <= cells_in;
            if (swap) cells_out <= pend_buf;
        end
    end
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: directed vectors for scan timing, frame buffering, freeze and reset
module tb_led_scan_controller;
    localparam int N = 8, P = 4, B = 1;

    logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, cells_valid = 1'b0;
    logic [63:0] cells_in = '0;
    logic        cells_ready, disp_ena, frame_done;
    logic [3:0]  x;
    logic [63:0] cells_out;

    int errors = 0, checks = 0;

    typedef struct {
        logic        ena;
        logic        valid;
        logic [63:0] din;
        logic [3:0]  ex;
        logic        edisp;
        logic        efd;
        logic        erdy;
        logic [63:0] eout;
    } vec_t;
    vec_t tbl[72];

    led_scan_controller #(.N(N), .PRESCALE(P), .BLANK(B)) dut (
        .clk(clk), .rst(rst), .ena(ena), .cells_in(cells_in), .cells_valid(cells_valid),
        .cells_ready(cells_ready), .x(x), .cells_out(cells_out), .disp_ena(disp_ena),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " x"}, 64'(x), 64'd0);
        chk({tag, " cells_out"}, cells_out, 64'd0);
        chk({tag, " cells_ready"}, 64'(cells_ready), 64'd1);
        chk({tag, " disp_ena"}, 64'(disp_ena), 64'd0);
        chk({tag, " frame_done"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        #2;
        chk_idle("reset");
        step(2);
        rst = 1'b0;

        // frame timing, capture at x=3, ignored second offer, swap at x 7->0
        for (int i = 0; i < 72; i++) begin
            int k;
            k = i + 1;
            tbl[i].ena   = 1'b1;
            tbl[i].valid = (k == 45) || (k == 46);
            tbl[i].din   = (k == 45) ? 64'hFF00_0000_0000_00FF : (k == 46 ? 64'h1 : 64'h0);
            tbl[i].ex    = 4'((k / 4) % 8);
            tbl[i].edisp = (k % 4) != 0;
            tbl[i].efd   = (k == 32) || (k == 64);
            tbl[i].erdy  = !(k >= 45 && k < 64);
            tbl[i].eout  = (k >= 64) ? 64'hFF00_0000_0000_00FF : 64'h0;
        end
        for (int i = 0; i < 72; i++) begin
            ena         = tbl[i].ena;
            cells_valid = tbl[i].valid;
            cells_in    = tbl[i].din;
            step(1);
            chk($sformatf("vec%0d x", i), 64'(x), 64'(tbl[i].ex));
            chk($sformatf("vec%0d disp_ena", i), 64'(disp_ena), 64'(tbl[i].edisp));
            chk($sformatf("vec%0d frame_done", i), 64'(frame_done), 64'(tbl[i].efd));
            chk($sformatf("vec%0d cells_ready", i), 64'(cells_ready), 64'(tbl[i].erdy));
            chk($sformatf("vec%0d cells_out", i), cells_out, tbl[i].eout);
        end
        cells_valid = 1'b0;

        // capture accepted on the wrap edge swaps one frame later
        step(23);
        cells_valid = 1'b1;
        cells_in    = 64'hA5A5_0000_0000_5A5A;
        step(1);
        cells_valid = 1'b0;
        chk("wrapcap fd", 64'(frame_done), 64'd1);
        chk("wrapcap no swap", cells_out, 64'hFF00_0000_0000_00FF);
        chk("wrapcap ready", 64'(cells_ready), 64'd0);
        step(31);
        chk("wrapcap hold", cells_out, 64'hFF00_0000_0000_00FF);
        step(1);
        chk("wrapcap swap", cells_out, 64'hA5A5_0000_0000_5A5A);
        chk("wrapcap ready back", 64'(cells_ready), 64'd1);

        // freeze at x=5, pcnt=2 with pending data
        step(20);
        cells_valid = 1'b1;
        cells_in    = 64'h3C;
        step(1);
        cells_valid = 1'b0;
        chk("freeze pend ready", 64'(cells_ready), 64'd0);
        step(1);
        chk("freeze pre x", 64'(x), 64'd5);
        chk("freeze pre out", cells_out, 64'hA5A5_0000_0000_5A5A);
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk($sformatf("freeze%0d x", i), 64'(x), 64'd5);
            chk($sformatf("freeze%0d disp", i), 64'(disp_ena), 64'd0);
            chk($sformatf("freeze%0d out", i), cells_out, 64'h3C);
            chk($sformatf("freeze%0d ready", i), 64'(cells_ready), 64'd1);
        end
        ena = 1'b1;
        step(1);
        chk("resume x", 64'(x), 64'd5);
        chk("resume disp", 64'(disp_ena), 64'd1);
        step(1);
        chk("resume next x", 64'(x), 64'd6);
        chk("resume next disp", 64'(disp_ena), 64'd0);

        // reset at x=6 with pending data discards it
        cells_valid = 1'b1;
        cells_in    = 64'h77;
        step(1);
        cells_valid = 1'b0;
        chk("rstpend ready", 64'(cells_ready), 64'd0);
        #3;
        rst = 1'b1;
        #1;
        chk_idle("async rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            step(1);
            chk($sformatf("post%0d x", j), 64'(x), 64'((j / 4) % 8));
            chk($sformatf("post%0d out", j), cells_out, 64'd0);
            chk($sformatf("post%0d fd", j), 64'(frame_done), 64'(j == 32));
            chk($sformatf("post%0d disp", j), 64'(disp_ena), 64'((j % 4) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
